// File: rtl/rst_seq_tick_gen_if.sv
// Control/status bundle for the reset sequencer: soft reset and tick period in,
// sequenced resets, ready/busy and the tick enable out.
interface rst_seq_tick_gen_if #(
    parameter int N_RST = 4,
    parameter int DIV_W = 8
);
    logic              sw_rst;
    logic [DIV_W-1:0]  div;
    logic [N_RST-1:0]  rst_n_o;
    logic              rdy;
    logic              busy;
    logic              tick;

    modport master (
        output sw_rst, div,
        input  rst_n_o, rdy, busy, tick
    );

    modport slave (
        input  sw_rst, div,
        output rst_n_o, rdy, busy, tick
    );
endinterface

// File: rtl/rst_seq_tick_gen.sv
// Reset sequencer and tick generator.
// Board reset (async, active low) is synchronised on release, then rst_n_o[0]
// is released HOLD_CYCLES edges after the trigger and each further bit
// STAGGER edges after the previous one. sw_rst restarts the sequence. In RUN a
// programmable divider emits a one-cycle tick every div+1 cycles.
module rst_seq_tick_gen #(
    parameter int N_RST       = 4,
    parameter int HOLD_CYCLES = 2,
    parameter int STAGGER     = 1,
    parameter int DIV_W       = 8
) (
    input  logic               clk,
    input  logic               reset,
    rst_seq_tick_gen_if.slave  bus
);

    localparam logic [1:0] ST_ASSERT  = 2'd0;
    localparam logic [1:0] ST_HOLD    = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;
    localparam logic [1:0] ST_RUN     = 2'd3;

    // Edge (relative to the trigger) at which the last reset bit is released.
    localparam int unsigned LAST = HOLD_CYCLES + (N_RST - 1) * STAGGER;
    localparam int unsigned CW   = $clog2(LAST + 1) + 1;

    logic             r_sync1;
    logic             r_sync_n;
    logic [1:0]       r_state;
    logic [CW-1:0]    r_cnt;
    logic [DIV_W-1:0] r_dcnt;
    logic [DIV_W-1:0] r_div;
    logic [N_RST-1:0] r_rst_n;
    logic             r_rdy;
    logic             r_busy;
    logic             r_tick;

    logic [CW-1:0]    w_m;
    logic [N_RST-1:0] w_rel;

    // Two-flop release synchroniser; r_sync1 high means r_sync_n rises on this edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1  <= 1'b0;
            r_sync_n <= 1'b0;
        end else begin
            r_sync1  <= 1'b1;
            r_sync_n <= r_sync1;
        end
    end

    // Release pattern for the edge being taken: bit k is free once the number
    // of edges since the trigger reaches HOLD_CYCLES + k*STAGGER.
    always_comb begin
        w_m   = r_cnt + CW'(1);
        w_rel = '0;
        for (int unsigned k = 0; k < N_RST; k++) begin
            w_rel[k] = (w_m >= CW'(HOLD_CYCLES + k * STAGGER));
        end
    end

    // Sequencer FSM, divider and all registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_ASSERT;
            r_cnt   <= '0;
            r_dcnt  <= '0;
            r_div   <= '0;
            r_rst_n <= '0;
            r_rdy   <= 1'b0;
            r_busy  <= 1'b1;
            r_tick  <= 1'b0;
        end else begin
            case (r_state)
                ST_ASSERT: begin
                    if (r_sync1 || (bus.sw_rst && r_sync_n)) begin
                        r_state <= ST_HOLD;
                        r_cnt   <= '0;
                    end
                end
                default: begin
                    if (bus.sw_rst) begin
                        // Restart with this edge as the new trigger; beats any tick.
                        r_state <= ST_HOLD;
                        r_cnt   <= '0;
                        r_dcnt  <= '0;
                        r_rst_n <= '0;
                        r_rdy   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_tick  <= 1'b0;
                    end else if (r_state != ST_RUN) begin
                        r_rst_n <= w_rel;
                        r_cnt   <= w_m;
                        if (w_m >= CW'(LAST)) begin
                            r_state <= ST_RUN;
                            r_rdy   <= 1'b1;
                            r_busy  <= 1'b0;
                            r_dcnt  <= '0;
                            r_div   <= bus.div;
                        end else if (w_m >= CW'(HOLD_CYCLES)) begin
                            r_state <= ST_RELEASE;
                        end
                    end else begin
                        if (r_dcnt == r_div) begin
                            r_tick <= 1'b1;
                            r_dcnt <= '0;
                            r_div  <= bus.div;
                        end else begin
                            r_tick <= 1'b0;
                            r_dcnt <= r_dcnt + DIV_W'(1);
                        end
                    end
                end
            endcase
        end
    end

    assign bus.rst_n_o = r_rst_n;
    assign bus.rdy     = r_rdy;
    assign bus.busy    = r_busy;
    assign bus.tick    = r_tick;

endmodule

// File: tb/tb_rst_seq_tick_gen.sv
// Directed bench for rst_seq_tick_gen (N_RST=3, HOLD_CYCLES=4, STAGGER=2,
// DIV_W=4) plus a STAGGER=0 / HOLD_CYCLES=1 variant sharing clock and reset.
module tb_rst_seq_tick_gen;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   e = 0;

    always #5 clk = ~clk;

    rst_seq_tick_gen_if #(.N_RST(3), .DIV_W(4)) bus ();
    rst_seq_tick_gen_if #(.N_RST(3), .DIV_W(4)) bus2 ();

    rst_seq_tick_gen #(.N_RST(3), .HOLD_CYCLES(4), .STAGGER(2), .DIV_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    rst_seq_tick_gen #(.N_RST(3), .HOLD_CYCLES(1), .STAGGER(0), .DIV_W(4)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    // Expected values for trigger edge t, div=3.
    function automatic logic [2:0] exp_rst(int ed, int t);
        logic [2:0] v;
        for (int k = 0; k < 3; k++) v[k] = (ed >= t + 4 + 2 * k);
        return v;
    endfunction

    function automatic logic exp_rdy(int ed, int t);
        return (ed >= t + 8);
    endfunction

    function automatic logic exp_tick(int ed, int t);
        return (ed > t + 8) && (((ed - t - 8) % 4) == 0);
    endfunction

    task automatic next_edge();
        @(posedge clk);
        #1;
        e = e + 1;
    endtask

    // Reset low for a few edges, then released 2 time units after an edge.
    task automatic power_on();
        reset = 1'b0;
        bus.sw_rst = 1'b0;
        bus.div = 4'd3;
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b1;
        e = 0;
    endtask

    task automatic test_reset();
        bus.sw_rst = 1'b0;
        bus.div = 4'd3;
        bus2.sw_rst = 1'b0;
        bus2.div = 4'd3;
        reset = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++;
        if (bus.rst_n_o !== 3'b000) begin errors++; $display("FAIL reset_rst_n got %b exp 000", bus.rst_n_o); end
        checks++;
        if (bus.rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy got %b exp 0", bus.rdy); end
        checks++;
        if (bus.busy !== 1'b1) begin errors++; $display("FAIL reset_busy got %b exp 1", bus.busy); end
        checks++;
        if (bus.tick !== 1'b0) begin errors++; $display("FAIL reset_tick got %b exp 0", bus.tick); end
        checks++;
        if (bus2.rst_n_o !== 3'b000) begin errors++; $display("FAIL reset_v_rst_n got %b exp 000", bus2.rst_n_o); end
    endtask

    // Tests 1 and 6: power-on sequence for both configurations.
    task automatic test_power_on();
        power_on();
        for (int i = 1; i <= 26; i++) begin
            next_edge();
            checks++;
            if (bus.rst_n_o !== exp_rst(e, 2)) begin errors++; $display("FAIL pon_rst_n e=%0d got %b exp %b", e, bus.rst_n_o, exp_rst(e, 2)); end
            checks++;
            if (bus.rdy !== exp_rdy(e, 2)) begin errors++; $display("FAIL pon_rdy e=%0d got %b exp %b", e, bus.rdy, exp_rdy(e, 2)); end
            checks++;
            if (bus.busy !== !exp_rdy(e, 2)) begin errors++; $display("FAIL pon_busy e=%0d got %b exp %b", e, bus.busy, !exp_rdy(e, 2)); end
            checks++;
            if (bus.tick !== exp_tick(e, 2)) begin errors++; $display("FAIL pon_tick e=%0d got %b exp %b", e, bus.tick, exp_tick(e, 2)); end
            if (e <= 6) begin
                checks++;
                if (bus2.rst_n_o !== ((e >= 3) ? 3'b111 : 3'b000)) begin errors++; $display("FAIL var_rst_n e=%0d got %b", e, bus2.rst_n_o); end
                checks++;
                if (bus2.rdy !== (e >= 3)) begin errors++; $display("FAIL var_rdy e=%0d got %b", e, bus2.rdy); end
            end
        end
    endtask

    // Test 2: async assert while a tick is high, then full re-run.
    task automatic test_async_reset();
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (bus.rst_n_o !== 3'b000) begin errors++; $display("FAIL async_rst_n got %b exp 000", bus.rst_n_o); end
        checks++;
        if (bus.rdy !== 1'b0) begin errors++; $display("FAIL async_rdy got %b exp 0", bus.rdy); end
        checks++;
        if (bus.tick !== 1'b0) begin errors++; $display("FAIL async_tick got %b exp 0", bus.tick); end
        checks++;
        if (bus.busy !== 1'b1) begin errors++; $display("FAIL async_busy got %b exp 1", bus.busy); end
        #3;
        reset = 1'b1;
        e = 0;
        for (int i = 1; i <= 14; i++) begin
            next_edge();
            checks++;
            if (bus.rst_n_o !== exp_rst(e, 2)) begin errors++; $display("FAIL rerun_rst_n e=%0d got %b exp %b", e, bus.rst_n_o, exp_rst(e, 2)); end
            checks++;
            if (bus.tick !== exp_tick(e, 2)) begin errors++; $display("FAIL rerun_tick e=%0d got %b exp %b", e, bus.tick, exp_tick(e, 2)); end
        end
    endtask

    // Test 3: one-cycle sw_rst sampled at edge 9, mid-stagger.
    task automatic test_sw_rst_mid();
        power_on();
        for (int i = 1; i <= 8; i++) next_edge();
        bus.sw_rst = 1'b1;
        next_edge();
        bus.sw_rst = 1'b0;
        checks++;
        if (bus.rst_n_o !== 3'b000) begin errors++; $display("FAIL swmid_clear got %b exp 000", bus.rst_n_o); end
        for (int i = 10; i <= 25; i++) begin
            next_edge();
            checks++;
            if (bus.rst_n_o !== exp_rst(e, 9)) begin errors++; $display("FAIL swmid_rst_n e=%0d got %b exp %b", e, bus.rst_n_o, exp_rst(e, 9)); end
            checks++;
            if (bus.rdy !== exp_rdy(e, 9)) begin errors++; $display("FAIL swmid_rdy e=%0d got %b exp %b", e, bus.rdy, exp_rdy(e, 9)); end
            checks++;
            if (bus.tick !== exp_tick(e, 9)) begin errors++; $display("FAIL swmid_tick e=%0d got %b exp %b", e, bus.tick, exp_tick(e, 9)); end
        end
    endtask

    // Test 4: div 3->0 two cycles after the tick at 14, then 0->15.
    task automatic test_div_change();
        logic exp_t;
        power_on();
        for (int i = 1; i <= 16; i++) next_edge();
        bus.div = 4'd0;
        for (int i = 17; i <= 22; i++) begin
            next_edge();
            exp_t = (e >= 18);
            checks++;
            if (bus.tick !== exp_t) begin errors++; $display("FAIL div0_tick e=%0d got %b exp %b", e, bus.tick, exp_t); end
        end
        bus.div = 4'd15;
        for (int i = 23; i <= 40; i++) begin
            next_edge();
            exp_t = (e == 23) || (e == 39);
            checks++;
            if (bus.tick !== exp_t) begin errors++; $display("FAIL div15_tick e=%0d got %b exp %b", e, bus.tick, exp_t); end
        end
        bus.div = 4'd3;
    endtask

    // Test 5: sw_rst held over edges 12..14 in RUN; edge 14 would have ticked.
    task automatic test_sw_rst_hold();
        power_on();
        for (int i = 1; i <= 11; i++) next_edge();
        bus.sw_rst = 1'b1;
        for (int i = 12; i <= 27; i++) begin
            next_edge();
            if (e == 14) bus.sw_rst = 1'b0;
            checks++;
            if (bus.rst_n_o !== exp_rst(e, 14)) begin errors++; $display("FAIL swhold_rst_n e=%0d got %b exp %b", e, bus.rst_n_o, exp_rst(e, 14)); end
            checks++;
            if (bus.tick !== exp_tick(e, 14)) begin errors++; $display("FAIL swhold_tick e=%0d got %b exp %b", e, bus.tick, exp_tick(e, 14)); end
            checks++;
            if (bus.busy !== !exp_rdy(e, 14)) begin errors++; $display("FAIL swhold_busy e=%0d got %b exp %b", e, bus.busy, !exp_rdy(e, 14)); end
        end
    endtask

    initial begin
        test_reset();
        test_power_on();
        test_async_reset();
        test_sw_rst_mid();
        test_div_change();
        test_sw_rst_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
